pc_seq: RTL and testbench

//  Fetch-stage PC sequencer: owns the F-stage PC register and chooses each cycle's next PC.

---
 rtl/pc_seq_pkg.sv | 30 +++
 rtl/pc_seq_next_mux.sv | 53 +++++
 rtl/pc_seq.sv | 156 +++++++++++++++
 tb/tb_pc_seq.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared constants, state encoding and small PC helpers for the fetch-stage PC sequencer.
package pc_seq_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;

    typedef enum logic [1:0] {
        PCS_BOOT  = 2'd0,
        PCS_FETCH = 2'd1,
        PCS_WAIT  = 2'd2
    } pcs_state_e;

    typedef enum logic [2:0] {
        SEL_EXC  = 3'd0,
        SEL_ERET = 3'd1,
        SEL_BR   = 3'd2,
        SEL_PEND = 3'd3,
        SEL_HOLD = 3'd4,
        SEL_SEQ  = 3'd5
    } pc_sel_e;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    function automatic logic pc_misaligned(input logic [31:0] pc);
        return (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/pc_seq_next_mux.sv
// Combinational next-PC priority select: exception, eret, branch, pending redirect, hold, sequential.
import pc_seq_pkg::*;

module pc_next_mux #(
    parameter logic [31:0] EXC_VEC = DEF_EXC_VEC
) (
    input  logic        exc_req,
    input  logic        eret,
    input  logic        br_acc,
    input  logic        pend_v,
    input  logic        stall,
    input  logic [31:0] pc,
    input  logic [31:0] npc,
    input  logic [31:0] epc,
    input  logic [31:0] pend_pc,
    output logic [31:0] pc_nxt
);

    pc_sel_e sel_s;

    // Priority decode of the next-PC source
    always_comb begin
        sel_s = SEL_SEQ;
        if (exc_req) begin
            sel_s = SEL_EXC;
        end else if (eret) begin
            sel_s = SEL_ERET;
        end else if (br_acc) begin
            sel_s = SEL_BR;
        end else if (pend_v) begin
            sel_s = SEL_PEND;
        end else if (stall) begin
            sel_s = SEL_HOLD;
        end else begin
            sel_s = SEL_SEQ;
        end
    end

    // Source select onto the next-PC bus
    always_comb begin
        pc_nxt = pc;
        case (sel_s)
            SEL_EXC:  pc_nxt = EXC_VEC;
            SEL_ERET: pc_nxt = epc;
            SEL_BR:   pc_nxt = npc;
            SEL_PEND: pc_nxt = pend_pc;
            SEL_HOLD: pc_nxt = pc;
            SEL_SEQ:  pc_nxt = pc_plus4(pc);
            default:  pc_nxt = pc;
        endcase
    end

endmodule

// File: rtl/pc_seq.sv
// Fetch-stage PC sequencer: F-stage PC register, imem req/rdy handshake, one buffered redirect.
// Optional fetch alignment check enabled by defining PC_ALIGN_CHK_EN.
import pc_seq_pkg::*;

module pc_seq #(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] EXC_VEC  = DEF_EXC_VEC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] npc,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic        imem_req,
    input  logic        imem_rdy,
    output logic [31:0] pc_F,
    output logic [31:0] pc4_F,
    output logic        fetch_busy,
    output logic        adel_F
);

    pcs_state_e  state_r, state_nxt_s;
    logic [31:0] pc_r, pc_d_s, mux_pc_s;
    logic        pend_v_r, pend_v_d_s;
    logic [31:0] pend_pc_r, pend_pc_d_s;
    logic        imem_req_r, req_d_s, fetch_busy_r;
    logic        non_boot_s, br_acc_s, event_s, advance_s;

    assign non_boot_s = (state_r != PCS_BOOT);
    assign br_acc_s   = br_taken & ~stall;
    assign event_s    = non_boot_s & (exc_req | eret);
    // eret and exceptions redirect regardless of the handshake; otherwise PC moves only on an accepted fetch
    assign advance_s  = event_s | (non_boot_s & imem_req_r & imem_rdy);

    pc_next_mux #(.EXC_VEC(EXC_VEC)) u_next_mux (
        .exc_req (exc_req),
        .eret    (eret),
        .br_acc  (br_acc_s),
        .pend_v  (pend_v_r),
        .stall   (stall),
        .pc      (pc_r),
        .npc     (npc),
        .epc     (epc),
        .pend_pc (pend_pc_r),
        .pc_nxt  (mux_pc_s)
    );

    // Next state, next PC and pending-redirect update
    always_comb begin
        state_nxt_s = state_r;
        pc_d_s      = pc_r;
        pend_v_d_s  = pend_v_r;
        pend_pc_d_s = pend_pc_r;

        case (state_r)
            PCS_BOOT:  state_nxt_s = PCS_FETCH;
            PCS_FETCH: begin
                if (event_s) begin
                    state_nxt_s = PCS_FETCH;
                end else if (imem_req_r & ~imem_rdy) begin
                    state_nxt_s = PCS_WAIT;
                end else begin
                    state_nxt_s = PCS_FETCH;
                end
            end
            PCS_WAIT: begin
                if (event_s | imem_rdy) begin
                    state_nxt_s = PCS_FETCH;
                end else begin
                    state_nxt_s = PCS_WAIT;
                end
            end
            default:   state_nxt_s = PCS_BOOT;
        endcase

        if (advance_s) begin
            pc_d_s = mux_pc_s;
        end else begin
            pc_d_s = pc_r;
        end

        // A redirect that cannot be applied this cycle is parked; a later one overwrites it
        if (advance_s) begin
            pend_v_d_s = 1'b0;
        end else if (non_boot_s & br_acc_s) begin
            pend_v_d_s  = 1'b1;
            pend_pc_d_s = npc;
        end else begin
            pend_v_d_s  = pend_v_r;
            pend_pc_d_s = pend_pc_r;
        end
    end

`ifdef PC_ALIGN_CHK_EN
    logic adel_r;

    // Request output, suppressed while the presented PC is misaligned
    always_comb begin
        if (state_nxt_s == PCS_BOOT) begin
            req_d_s = 1'b0;
        end else begin
            req_d_s = ~pc_misaligned(pc_d_s);
        end
    end

    // Alignment flag tracks the PC being loaded
    always_ff @(posedge clk) begin
        if (reset) begin
            adel_r <= 1'b0;
        end else begin
            adel_r <= pc_misaligned(pc_d_s);
        end
    end

    assign adel_F = adel_r;
`else
    // Request output follows the next state
    always_comb begin
        if (state_nxt_s == PCS_BOOT) begin
            req_d_s = 1'b0;
        end else begin
            req_d_s = 1'b1;
        end
    end

    assign adel_F = 1'b0;
`endif

    // State, PC, pending redirect and registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= PCS_BOOT;
            pc_r         <= RESET_PC;
            pend_v_r     <= 1'b0;
            pend_pc_r    <= 32'h0000_0000;
            imem_req_r   <= 1'b0;
            fetch_busy_r <= 1'b1;
        end else begin
            state_r      <= state_nxt_s;
            pc_r         <= pc_d_s;
            pend_v_r     <= pend_v_d_s;
            pend_pc_r    <= pend_pc_d_s;
            imem_req_r   <= req_d_s;
            fetch_busy_r <= (state_nxt_s == PCS_BOOT) | (state_nxt_s == PCS_WAIT);
        end
    end

    assign pc_F       = pc_r;
    assign pc4_F      = pc_plus4(pc_r);
    assign imem_req   = imem_req_r;
    assign fetch_busy = fetch_busy_r;

endmodule

// File: tb/tb_pc_seq.sv
// Scoreboard bench for pc_seq: per-cycle expectations queued with stimulus, compared against captured outputs.
module tb_pc_seq;

    logic        clk = 1'b0;
    logic        reset, stall, br_taken, exc_req, eret, imem_rdy;
    logic [31:0] npc, epc;
    logic        imem_req, fetch_busy, adel_F;
    logic [31:0] pc_F, pc4_F;

    logic [66:0] exp_q[$];
    logic [66:0] obs_q[$];
    logic [66:0] e, o;
    int          vectors = 0;
    int          miscompares = 0;

    localparam logic [31:0] Z = 32'h0000_0000;

    pc_seq dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .br_taken   (br_taken),
        .npc        (npc),
        .exc_req    (exc_req),
        .eret       (eret),
        .epc        (epc),
        .imem_req   (imem_req),
        .imem_rdy   (imem_rdy),
        .pc_F       (pc_F),
        .pc4_F      (pc4_F),
        .fetch_busy (fetch_busy),
        .adel_F     (adel_F)
    );

    always #5 clk = ~clk;

    // One clock: drive inputs, queue the expected outputs after the edge, capture the actual outputs.
    task automatic cyc(input logic r, input logic st, input logic br, input logic [31:0] np,
                       input logic ex, input logic er, input logic [31:0] ep, input logic rd,
                       input logic [31:0] e_pc, input logic e_req, input logic e_busy, input logic e_adel);
        logic [31:0] e_pc4;
        reset = r; stall = st; br_taken = br; npc = np;
        exc_req = ex; eret = er; epc = ep; imem_rdy = rd;
        e_pc4 = e_pc + 32'd4;
        exp_q.push_back({e_pc, e_pc4, e_req, e_busy, e_adel});
        @(posedge clk);
        #1;
        obs_q.push_back({pc_F, pc4_F, imem_req, fetch_busy, adel_F});
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, Z, 1'b0, 1'b0, Z, 1'b1, 32'h3000, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, Z, 1'b0, 1'b0, Z, 1'b1, 32'h3000, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        cyc(1'b1, 1'b0, 1'b0, Z, 1'b0, 1'b0, Z, 1'b1, 32'h3000, 1'b0, 1'b1, 1'b0);
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, Z, 1'b0, 1'b0, Z, 1'b1, 32'h3004, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, Z, 1'b0, 1'b0, Z, 1'b1, 32'h3008, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, Z, 1'b0, 1'b0, Z, 1'b1, 32'h300C, 1'b1, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL reset v%0d: got pc=%h pc4=%h req=%b busy=%b adel=%b, need pc=%h pc4=%h req=%b busy=%b adel=%b",
                         vectors, o[66:35], o[34:3], o[2], o[1], o[0], e[66:35], e[34:3], e[2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_branch();
        do_reset();
        for (int i = 1; i <= 4; i++)
            cyc(1'b0, 1'b0, 1'b0, Z, 1'b0, 1'b0, Z, 1'b1, 32'h3000 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 32'h3400, 1'b0, 1'b0, Z, 1'b1, 32'h3010, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'h3400, 1'b0, 1'b0, Z, 1'b1, 32'h3400, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, Z, 1'b0, 1'b0, Z, 1'b1, 32'h3404, 1'b1, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL branch v%0d: got pc=%h pc4=%h req=%b busy=%b adel=%b, need pc=%h pc4=%h req=%b busy=%b adel=%b",
                         vectors, o[66:35], o[34:3], o[2], o[1], o[0], e[66:35], e[34:3], e[2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_wait_redirect();
        do_reset();
        for (int i = 1; i <= 8; i++)
            cyc(1'b0, 1'b0, 1'b0, Z, 1'b0, 1'b0, Z, 1'b1, 32'h3000 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, Z,        1'b0, 1'b0, Z, 1'b0, 32'h3020, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'h3100, 1'b0, 1'b0, Z, 1'b0, 32'h3020, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, Z,        1'b0, 1'b0, Z, 1'b0, 32'h3020, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, Z,        1'b0, 1'b0, Z, 1'b1, 32'h3100, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, Z,        1'b0, 1'b0, Z, 1'b1, 32'h3104, 1'b1, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL wait_redirect v%0d: got pc=%h pc4=%h req=%b busy=%b adel=%b, need pc=%h pc4=%h req=%b busy=%b adel=%b",
                         vectors, o[66:35], o[34:3], o[2], o[1], o[0], e[66:35], e[34:3], e[2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, Z,        1'b0, 1'b0, Z, 1'b0, 32'h3000, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'h3100, 1'b0, 1'b0, Z, 1'b0, 32'h3000, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'h3200, 1'b0, 1'b0, Z, 1'b0, 32'h3000, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, Z,        1'b0, 1'b0, Z, 1'b1, 32'h3200, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, Z,        1'b0, 1'b0, Z, 1'b1, 32'h3204, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, Z,        1'b0, 1'b0, Z, 1'b0, 32'h3204, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'h3600, 1'b0, 1'b0, Z, 1'b1, 32'h3600, 1'b1, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL back_to_back v%0d: got pc=%h pc4=%h req=%b busy=%b adel=%b, need pc=%h pc4=%h req=%b busy=%b adel=%b",
                         vectors, o[66:35], o[34:3], o[2], o[1], o[0], e[66:35], e[34:3], e[2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_exc_eret();
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, Z,        1'b0, 1'b0, Z,        1'b1, 32'h3004, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, Z,        1'b0, 1'b0, Z,        1'b0, 32'h3004, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'h3300, 1'b0, 1'b0, Z,        1'b0, 32'h3004, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'h3300, 1'b1, 1'b1, 32'h3ABC, 1'b0, 32'h4180, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, Z,        1'b0, 1'b1, 32'h3024, 1'b0, 32'h3024, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, Z,        1'b0, 1'b0, Z,        1'b1, 32'h3028, 1'b1, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL exc_eret v%0d: got pc=%h pc4=%h req=%b busy=%b adel=%b, need pc=%h pc4=%h req=%b busy=%b adel=%b",
                         vectors, o[66:35], o[34:3], o[2], o[1], o[0], e[66:35], e[34:3], e[2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_align();
        do_reset();
`ifdef PC_ALIGN_CHK_EN
        cyc(1'b0, 1'b0, 1'b1, 32'h3402, 1'b0, 1'b0, Z, 1'b1, 32'h3402, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, Z,        1'b0, 1'b0, Z, 1'b1, 32'h3402, 1'b0, 1'b0, 1'b1);
`else
        cyc(1'b0, 1'b0, 1'b1, 32'h3402, 1'b0, 1'b0, Z, 1'b1, 32'h3402, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, Z,        1'b0, 1'b0, Z, 1'b1, 32'h3406, 1'b1, 1'b0, 1'b0);
`endif
        cyc(1'b0, 1'b0, 1'b0, Z,        1'b1, 1'b0, Z, 1'b1, 32'h4180, 1'b1, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL align v%0d: got pc=%h pc4=%h req=%b busy=%b adel=%b, need pc=%h pc4=%h req=%b busy=%b adel=%b",
                         vectors, o[66:35], o[34:3], o[2], o[1], o[0], e[66:35], e[34:3], e[2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, Z, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, Z,             1'b0, 1'b0, Z, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, Z,             1'b0, 1'b0, Z, 1'b1, 32'h0000_0004, 1'b1, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL wrap v%0d: got pc=%h pc4=%h req=%b busy=%b adel=%b, need pc=%h pc4=%h req=%b busy=%b adel=%b",
                         vectors, o[66:35], o[34:3], o[2], o[1], o[0], e[66:35], e[34:3], e[2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, Z,        1'b0, 1'b0, Z, 1'b0, 32'h3000, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'h3500, 1'b0, 1'b0, Z, 1'b0, 32'h3000, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, Z,        1'b0, 1'b0, Z, 1'b0, 32'h3000, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, Z,        1'b0, 1'b0, Z, 1'b1, 32'h3000, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, Z,        1'b0, 1'b0, Z, 1'b1, 32'h3004, 1'b1, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL reset_in_wait v%0d: got pc=%h pc4=%h req=%b busy=%b adel=%b, need pc=%h pc4=%h req=%b busy=%b adel=%b",
                         vectors, o[66:35], o[34:3], o[2], o[1], o[0], e[66:35], e[34:3], e[2], e[1], e[0]);
            end
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; br_taken = 1'b0; npc = Z;
        exc_req = 1'b0; eret = 1'b0; epc = Z; imem_rdy = 1'b0;
        @(negedge clk);
        test_reset();
        test_branch();
        test_wait_redirect();
        test_back_to_back();
        test_exc_eret();
        test_align();
        test_wrap();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
